// File: rtl/sys_bridge_timer.sv
// -----------------------------------------------------------------------------
// sys_bridge_timer
//
// Memory-mapped device responder on the CPU data-memory side. Decodes the CPU's
// M-stage address / store data / store enable, hosts two identical countdown
// timers (T0 at T0_BASE, T1 at T1_BASE) and returns combinational read data
// for the CPU DIN path. Each timer raises an interrupt request toward the CPU.
//
// Register block per timer (byte offset from base, word access only):
//   0x0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, otherwise one-shot),
//              [3] IM (interrupt mask, 1 = request enabled), [31:4] read 0
//   0x4 PRESET reload value
//   0x8 COUNT  current count, read-only
//
// Ports:
//   clk     in   1  system clock, all state on rising edge
//   reset   in   1  synchronous active-low reset
//   addr    in  32  CPU M-stage byte address
//   wdata   in  32  CPU M-stage store data
//   we      in   1  CPU M-stage store enable
//   rdata   out 32  read data (combinational, 0 when unmapped)
//   hit     out  1  addr selects a mapped timer register word
//   intrp0  out  1  timer 0 interrupt request
//   intrp1  out  1  timer 1 interrupt request
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// sys_bridge_timer_unit
//
// One countdown timer with its own address decode and register file.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   addr, wdata, we CPU store/load request
//   rdata           this timer's read data (0 unless hit)
//   hit             addr selects one of this timer's three register words
//   irq             irq_flag AND CTRL.IM
// -----------------------------------------------------------------------------
module sys_bridge_timer_unit #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_AUTO = 2'b01;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        flag_q, flag_d;

  logic [31:0] offset;
  logic        sel_ctrl;
  logic        sel_preset;
  logic        sel_count;
  logic        wr_ctrl;
  logic        wr_preset;

  // Unsigned subtraction: addresses below BASE wrap to huge offsets and miss.
  assign offset     = addr - BASE;
  assign hit        = (offset < 32'd12) && (offset[1:0] == 2'b00);
  assign sel_ctrl   = hit && (offset[3:2] == 2'd0);
  assign sel_preset = hit && (offset[3:2] == 2'd1);
  assign sel_count  = hit && (offset[3:2] == 2'd2);
  assign wr_ctrl    = we && sel_ctrl;
  assign wr_preset  = we && sel_preset;

  always_comb begin
    rdata = 32'h0;
    if (sel_ctrl) begin
      rdata = {28'h0, ctrl_q};
    end else if (sel_preset) begin
      rdata = preset_q;
    end else if (sel_count) begin
      rdata = count_q;
    end
  end

  assign irq = flag_q & ctrl_q[3];

  // Next-state logic. CPU writes are applied first; FSM actions that follow
  // override them where the FSM must win (irq_flag set), while the one-shot
  // EN clear is suppressed when the CPU writes CTRL on the same edge.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    if (wr_ctrl) begin
      ctrl_d = wdata[3:0];
      flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d = wdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (ctrl_q[0]) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl_q[0]) begin
          state_d = ST_IDLE;
        end else if (count_q != 32'h0) begin
          count_d = count_q - 32'd1;
        end else begin
          state_d = ST_INT;
          flag_d  = 1'b1;
        end
      end
      ST_INT: begin
        if (ctrl_q[2:1] == MODE_AUTO) begin
          // Auto-reload: flag lives for exactly one cycle.
          state_d = ST_LOAD;
          flag_d  = 1'b0;
        end else begin
          // One-shot (MODE 00/10/11): stop; flag held until CTRL write.
          state_d = ST_IDLE;
          if (!wr_ctrl) begin
            ctrl_d[0] = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

endmodule

module sys_bridge_timer #(
  parameter logic [31:0] T0_BASE = 32'h0000_7F00,
  parameter logic [31:0] T1_BASE = 32'h0000_7F10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        intrp0,
  output logic        intrp1
);

  logic [31:0] unit_rdata [2];
  logic        unit_hit   [2];
  logic        unit_irq   [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_timer
      localparam logic [31:0] UNIT_BASE = (gi == 0) ? T0_BASE : T1_BASE;

      sys_bridge_timer_unit #(
        .BASE (UNIT_BASE)
      ) u_timer (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .we    (we),
        .rdata (unit_rdata[gi]),
        .hit   (unit_hit[gi]),
        .irq   (unit_irq[gi])
      );
    end
  endgenerate

  // Each unit drives zero unless hit, so OR-combining selects the hit one.
  assign rdata  = unit_rdata[0] | unit_rdata[1];
  assign hit    = unit_hit[0] | unit_hit[1];
  assign intrp0 = unit_irq[0];
  assign intrp1 = unit_irq[1];

endmodule

// File: tb/tb_sys_bridge_timer.sv
// -----------------------------------------------------------------------------
// tb_sys_bridge_timer
//
// Self-checking bench for sys_bridge_timer: decode/reset vector table, a
// write/readback table, hand-written timing sequences, and a randomized run
// compared against a behavioural model of the two timers.
// -----------------------------------------------------------------------------
module tb_sys_bridge_timer;

  localparam logic [31:0] T0 = 32'h0000_7F00;
  localparam logic [31:0] T1 = 32'h0000_7F10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        intrp0;
  logic        intrp1;

  int n_checks = 0;
  int n_fail   = 0;

  sys_bridge_timer #(
    .T0_BASE (T0),
    .T1_BASE (T1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .hit    (hit),
    .intrp0 (intrp0),
    .intrp1 (intrp1)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: per-timer phase (0 idle, 1 load, 2 counting, 3 expired)
  // ---------------------------------------------------------------------------
  logic [3:0]  m_ctrl  [2];
  logic [31:0] m_pre   [2];
  logic [31:0] m_cnt   [2];
  logic        m_flag  [2];
  int          m_phase [2];

  initial begin
    for (int t = 0; t < 2; t++) begin
      m_ctrl[t] = 4'h0; m_pre[t] = 32'h0; m_cnt[t] = 32'h0;
      m_flag[t] = 1'b0; m_phase[t] = 0;
    end
  end

  // Returns 1 and the timer / word index when a is a mapped register word.
  function automatic bit m_decode(input logic [31:0] a, output int t, output int r);
    logic [31:0] bases [2];
    bases[0] = T0; bases[1] = T1;
    t = 0; r = 0;
    if (a % 4 != 0) return 0;
    for (int i = 0; i < 2; i++) begin
      if (a >= bases[i] && a < bases[i] + 12) begin
        t = i; r = int'((a - bases[i]) / 4);
        return 1;
      end
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int t, r;
    if (!m_decode(a, t, r)) return 32'h0;
    case (r)
      0:       return {28'h0, m_ctrl[t]};
      1:       return m_pre[t];
      default: return m_cnt[t];
    endcase
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_step();
    int wt, wr;
    bit wv;
    if (!reset) begin
      for (int t = 0; t < 2; t++) begin
        m_ctrl[t] = 4'h0; m_pre[t] = 32'h0; m_cnt[t] = 32'h0;
        m_flag[t] = 1'b0; m_phase[t] = 0;
      end
      return;
    end
    wv = we && m_decode(addr, wt, wr);
    for (int t = 0; t < 2; t++) begin
      bit cw  = wv && wt == t && wr == 0;
      bit pw  = wv && wt == t && wr == 1;
      bit en  = m_ctrl[t][0];
      bit set_flag = 0;
      bit clr_en   = 0;
      bit pulse_end = 0;
      int nxt = m_phase[t];
      logic [31:0] ncnt = m_cnt[t];
      if (m_phase[t] == 0) begin
        if (en) nxt = 1;
      end else if (m_phase[t] == 1) begin
        ncnt = m_pre[t]; nxt = 2;
      end else if (m_phase[t] == 2) begin
        if (!en) nxt = 0;
        else if (m_cnt[t] > 0) ncnt = m_cnt[t] - 1;
        else begin nxt = 3; set_flag = 1; end
      end else begin
        if (m_ctrl[t][2:1] == 2'b01) begin nxt = 1; pulse_end = 1; end
        else begin nxt = 0; clr_en = 1; end
      end
      if (cw) m_ctrl[t] = wdata[3:0];
      else if (clr_en) m_ctrl[t][0] = 1'b0;
      if (pw) m_pre[t] = wdata;
      if (set_flag) m_flag[t] = 1'b1;
      else if (cw || pulse_end) m_flag[t] = 1'b0;
      m_cnt[t] = ncnt;
      m_phase[t] = nxt;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
    addr = a; wdata = d; we = w;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    drive(a, d, 1'b1);
    step();
    drive(32'h0, 32'h0, 1'b0);
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    drive(a, 32'h0, 1'b0);
    #1;
    chk(name, rdata, exp);
  endtask

  task automatic check_model(input int cyc);
    string s;
    s = $sformatf("rand%0d", cyc);
    chk({s, "_rdata"}, rdata, m_read(addr));
    chk({s, "_hit"}, {31'h0, hit}, {31'h0, 1'(m_read(addr) | 0) == 1'b0 ? 1'b0 : 1'b0} | 32'(m_decode_hit(addr)));
    chk({s, "_intrp0"}, {31'h0, intrp0}, {31'h0, m_flag[0] & m_ctrl[0][3]});
    chk({s, "_intrp1"}, {31'h0, intrp1}, {31'h0, m_flag[1] & m_ctrl[1][3]});
  endtask

  function automatic bit m_decode_hit(input logic [31:0] a);
    int t, r;
    return m_decode(a, t, r);
  endfunction

  // ---------------------------------------------------------------------------
  // Vector tables
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] a;
    logic        exp_hit;
  } dec_row_t;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [31:0] raddr;
    logic [31:0] exp;
  } wr_row_t;

  dec_row_t dec_tbl [12];
  wr_row_t  wr_tbl  [10];

  initial begin
    dec_tbl[0]  = '{32'h7F00, 1'b1};
    dec_tbl[1]  = '{32'h7F04, 1'b1};
    dec_tbl[2]  = '{32'h7F08, 1'b1};
    dec_tbl[3]  = '{32'h7F0C, 1'b0};
    dec_tbl[4]  = '{32'h7F02, 1'b0};
    dec_tbl[5]  = '{32'h8000, 1'b0};
    dec_tbl[6]  = '{32'h7F10, 1'b1};
    dec_tbl[7]  = '{32'h7F14, 1'b1};
    dec_tbl[8]  = '{32'h7F18, 1'b1};
    dec_tbl[9]  = '{32'h7F1C, 1'b0};
    dec_tbl[10] = '{32'h7F05, 1'b0};
    dec_tbl[11] = '{32'h0000, 1'b0};

    wr_tbl[0] = '{32'h7F04, 32'hDEADBEEF, 32'h7F04, 32'hDEADBEEF};
    wr_tbl[1] = '{32'h7F00, 32'hFFFFFFFE, 32'h7F00, 32'h0000000E};
    wr_tbl[2] = '{32'h7F08, 32'h00000055, 32'h7F08, 32'h00000000};
    wr_tbl[3] = '{32'h7F14, 32'h12345678, 32'h7F14, 32'h12345678};
    wr_tbl[4] = '{32'h7F10, 32'h0000000C, 32'h7F10, 32'h0000000C};
    wr_tbl[5] = '{32'h7F18, 32'hFFFFFFFF, 32'h7F18, 32'h00000000};
    wr_tbl[6] = '{32'h7F05, 32'hAAAAAAAA, 32'h7F04, 32'hDEADBEEF};
    wr_tbl[7] = '{32'h7F0C, 32'h00000001, 32'h7F00, 32'h0000000E};
    wr_tbl[8] = '{32'h7F00, 32'h00000000, 32'h7F00, 32'h00000000};
    wr_tbl[9] = '{32'h7F10, 32'h00000000, 32'h7F04, 32'hDEADBEEF};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    #1;
    // Reset held two edges with random bus activity.
    for (int i = 0; i < 2; i++) begin
      drive(32'h7F00 + 32'($urandom_range(0, 7) * 4), $urandom, 1'($urandom_range(0, 1)));
      step();
    end
    drive(32'h0, 32'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      drive(dec_tbl[i].a, 32'h0, 1'b0);
      #1;
      chk($sformatf("rst_hit_%h", dec_tbl[i].a), {31'h0, hit}, {31'h0, dec_tbl[i].exp_hit});
      chk($sformatf("rst_rdata_%h", dec_tbl[i].a), rdata, 32'h0);
      if (i % 2 == 1) step();
    end
    chk("rst_intrp0", {31'h0, intrp0}, 32'h0);
    chk("rst_intrp1", {31'h0, intrp1}, 32'h0);
    reset = 1'b1;
    step();

    // Write / readback table.
    for (int i = 0; i < 10; i++) begin
      wr(wr_tbl[i].waddr, wr_tbl[i].wdat);
      rd($sformatf("wr%0d_%h", i, wr_tbl[i].raddr), wr_tbl[i].raddr, wr_tbl[i].exp);
    end

    // One-shot: PRESET0=5, CTRL0=0x9 at E0 -> intrp0 after E8.
    wr(T0 + 4, 5);
    wr(T0, 32'h9);
    for (int k = 1; k <= 7; k++) step();
    chk("os_intrp0_E7", {31'h0, intrp0}, 32'h0);
    step();
    chk("os_intrp0_E8", {31'h0, intrp0}, 32'h1);
    step(); step();
    chk("os_intrp0_held", {31'h0, intrp0}, 32'h1);
    rd("os_count0", T0 + 8, 32'h0);
    rd("os_ctrl0", T0, 32'h8);
    wr(T0, 32'h8);
    chk("os_intrp0_clr", {31'h0, intrp0}, 32'h0);

    // Auto-reload on T1: PRESET1=2, CTRL1=0xB -> pulses at E5, E10, E15.
    wr(T1 + 4, 2);
    wr(T1, 32'hB);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("ar_intrp1_E%0d", k), {31'h0, intrp1},
          {31'h0, 1'(k >= 5 && (k - 5) % 5 == 0)});
      if (k == 16) chk("ar_intrp0", {31'h0, intrp0}, 32'h0);
    end
    wr(T1, 32'h0);

    // Mask: IM=0 keeps intrp0 low; then IM=1 run raises it.
    wr(T0 + 4, 1);
    wr(T0, 32'h1);
    for (int k = 1; k <= 5; k++) step();
    chk("mask_intrp0", {31'h0, intrp0}, 32'h0);
    rd("mask_count0", T0 + 8, 32'h0);
    rd("mask_ctrl0", T0, 32'h0);
    wr(T0, 32'h8);
    chk("mask_flag_cleared", {31'h0, intrp0}, 32'h0);
    wr(T0, 32'h9);
    for (int k = 1; k <= 3; k++) step();
    chk("im_intrp0_E3", {31'h0, intrp0}, 32'h0);
    step();
    chk("im_intrp0_E4", {31'h0, intrp0}, 32'h1);
    wr(T0, 32'h0);
    chk("im_intrp0_clr", {31'h0, intrp0}, 32'h0);

    // Disable mid-count: PRESET0=100, disable written at E10 -> frozen at 92.
    wr(T0 + 4, 100);
    wr(T0, 32'h1);
    for (int k = 1; k <= 9; k++) step();
    wr(T0, 32'h0);
    step();
    rd("dis_count_frozen", T0 + 8, 32'd92);
    step();
    rd("dis_count_still", T0 + 8, 32'd92);
    wr(T0, 32'h1);
    step();
    rd("dis_count_E1", T0 + 8, 32'd92);
    step();
    rd("dis_count_reload", T0 + 8, 32'd100);
    wr(T0, 32'h0);

    // PRESET=0 -> interrupt after E3; CTRL write in one-shot INT wins.
    wr(T0 + 4, 0);
    wr(T0, 32'h9);
    step(); step();
    chk("p0_intrp0_E2", {31'h0, intrp0}, 32'h0);
    step();
    chk("p0_intrp0_E3", {31'h0, intrp0}, 32'h1);
    wr(T0, 32'h9);
    chk("race_intrp0_clr", {31'h0, intrp0}, 32'h0);
    rd("race_ctrl0", T0, 32'h9);
    step(); step();
    chk("race_intrp0_E6", {31'h0, intrp0}, 32'h0);
    step();
    chk("race_intrp0_E7", {31'h0, intrp0}, 32'h1);
    wr(T0, 32'h0);

    // CTRL write on the CNT->INT edge: flag set wins.
    wr(T0, 32'h9);
    step(); step();
    wr(T0, 32'h9);
    chk("setwins_intrp0", {31'h0, intrp0}, 32'h1);
    step();
    chk("setwins_intrp0_held", {31'h0, intrp0}, 32'h1);
    rd("setwins_ctrl0", T0, 32'h8);
    wr(T0, 32'h0);

    // COUNT write ignored, misaligned store ignored, write during reset ignored.
    wr(T0 + 8, 32'h55);
    rd("cnt_wr_ignored", T0 + 8, 32'h0);
    wr(T0 + 4, 32'h11);
    wr(T0 + 6, 32'h33);
    rd("misaligned_ignored", T0 + 4, 32'h11);
    reset = 1'b0;
    wr(T1 + 4, 32'h77);
    reset = 1'b1;
    rd("rst_wr_ignored", T1 + 4, 32'h0);
    rd("rst_preset0", T0 + 4, 32'h0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 11);
      if (sel < 4)       a = T0 + 32'(sel * 4);
      else if (sel < 8)  a = T1 + 32'((sel - 4) * 4);
      else if (sel == 8) a = T0 + 32'h5;
      else if (sel == 9) a = 32'h8000;
      else               a = T0 + 32'($urandom_range(0, 3) * 4);
      reset = ($urandom_range(0, 299) != 0);
      drive(a, ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) == 0));
      #1;
      if (i % 3 == 0) check_model(i);
      step();
    end
    reset = 1'b1;
    drive(32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
